// File: rtl/instr_seq_pkg.sv
// Shared constants and types for the instruction sequencer.
//
// Contents:
//   PC_W, WORD_W   program counter and instruction word widths
//   WDOG_W/MAX     watchdog counter width and timeout value
//   OP_*           opcode field values (op = word[8:6])
//   state_t, St*   sequencer FSM state encoding
//   word_op()      extracts the opcode field from a word
package instr_seq_pkg;

  localparam int unsigned PC_W     = 5;
  localparam int unsigned WORD_W   = 9;
  localparam int unsigned WDOG_W   = 4;
  localparam int unsigned WDOG_MAX = 15;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StFetch    = 3'd1;
  localparam state_t StLatch    = 3'd2;
  localparam state_t StIssue    = 3'd3;
  localparam state_t StImmRd    = 3'd4;
  localparam state_t StImmLatch = 3'd5;
  localparam state_t StWait     = 3'd6;
  localparam state_t StHalt     = 3'd7;

  function automatic logic [2:0] word_op(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3];
  endfunction

endpackage

// File: rtl/instr_seq_wdog.sv
// Watchdog for the WAIT state of the instruction sequencer.
// Only instantiated when INSTR_SEQ_WATCHDOG_EN is defined.
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   clr          clear the counter (instruction being issued)
//   count        a WAIT cycle in which the instruction has not retired
//   err_clr      a start has been accepted; drops the sticky error
//   expire       this WAIT cycle is the last one allowed
//   err          sticky timeout flag
module instr_seq_wdog
  import instr_seq_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic count,
  input  logic err_clr,
  output logic expire,
  output logic err
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  always_comb begin
    // The 15th un-retired WAIT cycle takes the counter to WDOG_MAX.
    expire = count && (cnt_q == WDOG_W'(WDOG_MAX - 1));

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (count && (cnt_q != WDOG_W'(WDOG_MAX))) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end

    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end else if (expire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches words from program memory, presents each
// instruction (and the immediate of an mvi) on din, pulses run once per
// instruction and waits for the control unit to retire it with done.
// Optional watchdog on the WAIT state: define INSTR_SEQ_WATCHDOG_EN.
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   start        begin/resume issuing from pc (IDLE or HALT only)
//   stop         finish the current instruction, then go IDLE
//   done         instruction retired (one-cycle pulse)
//   mem_rdata    program memory data, valid the cycle after mem_rd
//   mem_rd       program memory read strobe
//   mem_addr     program memory address (always pc)
//   din          registered instruction / immediate word
//   run          din holds an instruction to execute
//   busy         not in IDLE or HALT
//   halted       in HALT
//   pc           program counter
//   err          watchdog timeout, sticky until start (watchdog builds only)
module instr_seq
  import instr_seq_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              done,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic [PC_W-1:0]   mem_addr,
  output logic [WORD_W-1:0] din,
  output logic              run,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
`ifdef INSTR_SEQ_WATCHDOG_EN
  ,
  output logic              err
`endif
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              done_seen_q, done_seen_d;
  logic              stop_pend_q, stop_pend_d;

  logic busy_s;
  logic retire;
  logic wdog_expire;

  assign busy_s = (state_q != StIdle) && (state_q != StHalt);
  // A done that arrived early is held in done_seen until WAIT consumes it.
  assign retire = done || done_seen_q;

`ifdef INSTR_SEQ_WATCHDOG_EN
  logic wdog_clr, wdog_count, wdog_err_clr;

  assign wdog_clr     = (state_q == StLatch) && (state_d == StIssue);
  assign wdog_count   = (state_q == StWait) && !retire;
  assign wdog_err_clr = ((state_q == StIdle) || (state_q == StHalt)) && (state_d == StFetch);

  instr_seq_wdog u_wdog (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (wdog_clr),
    .count   (wdog_count),
    .err_clr (wdog_err_clr),
    .expire  (wdog_expire),
    .err     (err)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    din_d       = din_q;
    done_seen_d = done_seen_q;
    stop_pend_d = stop_pend_q || (stop && busy_s);

    case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        din_d   = mem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = (word_op(mem_rdata) == OP_HALT) ? StHalt : StIssue;
      end
      StIssue: begin
        state_d = (word_op(din_q) == OP_MVI) ? StImmRd : StWait;
      end
      StImmRd: begin
        state_d = StImmLatch;
      end
      StImmLatch: begin
        din_d   = mem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = StWait;
      end
      StWait: begin
        // Live stop counts too, so a stop coinciding with done is honoured now.
        if (retire) begin
          state_d = stop_pend_d ? StIdle : StFetch;
        end else if (wdog_expire) begin
          state_d = StIdle;
        end
      end
      StHalt: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // done is only meaningful once the instruction has been issued.
    if (done && ((state_q == StImmRd) || (state_q == StImmLatch) || (state_q == StWait))) begin
      done_seen_d = 1'b1;
    end
    if ((state_q != StIssue) && (state_d == StIssue)) done_seen_d = 1'b0;
    if ((state_q != StIdle) && (state_d == StIdle)) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      din_q       <= '0;
      done_seen_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      din_q       <= din_d;
      done_seen_q <= done_seen_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign mem_rd   = (state_q == StFetch) || (state_q == StImmRd);
  assign mem_addr = pc_q;
  assign din      = din_q;
  assign run      = (state_q == StIssue);
  assign busy     = busy_s;
  assign halted   = (state_q == StHalt);
  assign pc       = pc_q;

endmodule

// File: tb/tb_instr_seq.sv
// Directed self-checking bench for instr_seq with a one-cycle-latency
// program memory model. Watchdog scenario compiled in with
// INSTR_SEQ_WATCHDOG_EN.
module tb_instr_seq;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       done = 1'b0;
  logic [8:0] mem_rdata = '0;
  logic       mem_rd;
  logic [4:0] mem_addr;
  logic [8:0] din;
  logic       run;
  logic       busy;
  logic       halted;
  logic [4:0] pc;
`ifdef INSTR_SEQ_WATCHDOG_EN
  logic       err;
`endif

  logic [8:0] mem [32];
  int n_checks = 0;
  int n_fail = 0;

  instr_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .done      (done),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .din       (din),
    .run       (run),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc)
`ifdef INSTR_SEQ_WATCHDOG_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    done   = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic fill_mem(input logic [8:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    n_checks++;
    if ({run, mem_rd, busy, halted, pc, din} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", {run, mem_rd, busy, halted, pc, din}, 18'd0);
    end
    resetn = 1'b1;
    step();
    n_checks++;
    if ({run, mem_rd, busy, halted, pc, din} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %h want %h", {run, mem_rd, busy, halted, pc, din}, 18'd0);
    end
    // start in the very first cycle after release is honoured
    fill_mem(9'h1C0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr, busy} !== {1'b1, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_start: got %h want %h", {mem_rd, mem_addr, busy},
               {1'b1, 5'd0, 1'b1});
    end
    // start and stop together in IDLE: stay idle
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if ({mem_rd, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_start_stop: got %b want %b", {mem_rd, busy}, 2'b00);
    end
  endtask

  task automatic test_mvi();
    fill_mem(9'h1C0);
    mem[0] = 9'h040;
    mem[1] = 9'h005;
    do_reset();
    start = 1'b1;
    step();                                 // FETCH
    start = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr, run} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mvi_fetch: got %h want %h", {mem_rd, mem_addr, run}, {1'b1, 5'd0, 1'b0});
    end
    step();                                 // LATCH
    step();                                 // ISSUE
    n_checks++;
    if ({run, din, pc} !== {1'b1, 9'h040, 5'd1}) begin
      n_fail++;
      $display("FAIL mvi_issue: got %h want %h", {run, din, pc}, {1'b1, 9'h040, 5'd1});
    end
    step();                                 // IMM_RD
    n_checks++;
    if ({run, mem_rd, mem_addr} !== {1'b0, 1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL mvi_imm_rd: got %h want %h", {run, mem_rd, mem_addr}, {1'b0, 1'b1, 5'd1});
    end
    step();                                 // IMM_LATCH, done two cycles after run
    pulse_done();                           // WAIT
    n_checks++;
    if ({din, pc, busy, mem_rd, run} !== {9'h005, 5'd2, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mvi_wait: got %h want %h", {din, pc, busy, mem_rd, run},
               {9'h005, 5'd2, 1'b1, 1'b0, 1'b0});
    end
    step();                                 // FETCH @2 via captured done
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL mvi_next_fetch: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd2});
    end
  endtask

  // Continues from test_mvi: mem[2] and mem[3] hold halt words.
  task automatic test_halt();
    logic saw_run;
    saw_run = 1'b0;
    step();                                 // LATCH
    if (run) saw_run = 1'b1;
    step();                                 // HALT
    if (run) saw_run = 1'b1;
    n_checks++;
    if ({halted, busy, run, mem_rd, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL halt_state: got %h want %h", {halted, busy, run, mem_rd, pc},
               {1'b1, 1'b0, 1'b0, 1'b0, 5'd3});
    end
    step();
    if (run) saw_run = 1'b1;
    step();
    if (run) saw_run = 1'b1;
    n_checks++;
    if ({saw_run, halted} !== 2'b01) begin
      n_fail++;
      $display("FAIL halt_no_run: got %b want %b", {saw_run, halted}, 2'b01);
    end
    start = 1'b1;
    step();                                 // FETCH @3
    start = 1'b0;
    n_checks++;
    if ({halted, mem_rd, mem_addr, busy} !== {1'b0, 1'b1, 5'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_resume: got %h want %h", {halted, mem_rd, mem_addr, busy},
               {1'b0, 1'b1, 5'd3, 1'b1});
    end
    step();                                 // LATCH
    step();                                 // HALT, pc=4
    stop = 1'b1;
    step();                                 // IDLE
    stop = 1'b0;
    n_checks++;
    if ({halted, busy, pc} !== {1'b0, 1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL halt_stop: got %h want %h", {halted, busy, pc}, {1'b0, 1'b0, 5'd4});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd4}) begin
      n_fail++;
      $display("FAIL idle_resume: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd4});
    end
  endtask

  task automatic test_fast_done();
    fill_mem(9'h1C0);
    mem[0] = 9'h00A;
    mem[1] = 9'h00A;
    do_reset();
    start = 1'b1;
    step();                                 // FETCH
    start = 1'b0;
    step();                                 // LATCH
    step();                                 // ISSUE
    n_checks++;
    if ({run, din, pc} !== {1'b1, 9'h00A, 5'd1}) begin
      n_fail++;
      $display("FAIL fast_issue: got %h want %h", {run, din, pc}, {1'b1, 9'h00A, 5'd1});
    end
    step();                                 // WAIT, done right after run
    pulse_done();                           // FETCH @1
    n_checks++;
    if ({mem_rd, mem_addr, busy} !== {1'b1, 5'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL fast_done_fetch: got %h want %h", {mem_rd, mem_addr, busy},
               {1'b1, 5'd1, 1'b1});
    end
    // done during FETCH and LATCH must be ignored
    done = 1'b1;
    step();                                 // LATCH
    step();                                 // ISSUE
    done = 1'b0;
    step();                                 // WAIT
    step();
    step();
    n_checks++;
    if ({busy, mem_rd, run, pc} !== {1'b1, 1'b0, 1'b0, 5'd2}) begin
      n_fail++;
      $display("FAIL ign_done_wait: got %h want %h", {busy, mem_rd, run, pc},
               {1'b1, 1'b0, 1'b0, 5'd2});
    end
    pulse_done();
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL ign_done_release: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd2});
    end
  endtask

  task automatic test_stop();
    logic saw_rd;
    fill_mem(9'h1C0);
    mem[0] = 9'h040;                        // mvi
    mem[1] = 9'h005;
    mem[2] = 9'h00A;                        // mv
    mem[3] = 9'h0D1;                        // sub
    mem[4] = 9'h08A;                        // add
    do_reset();
    start = 1'b1;
    step();                                 // FETCH @0
    start = 1'b0;
    repeat (5) step();                      // L, I, IR, IL, W
    pulse_done();                           // FETCH @2
    repeat (3) step();
    pulse_done();                           // FETCH @3
    repeat (3) step();
    pulse_done();                           // FETCH @4
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd4}) begin
      n_fail++;
      $display("FAIL stop_fetch4: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd4});
    end
    step();
    step();                                 // ISSUE add
    n_checks++;
    if ({run, din} !== {1'b1, 9'h08A}) begin
      n_fail++;
      $display("FAIL stop_add_issue: got %h want %h", {run, din}, {1'b1, 9'h08A});
    end
    step();                                 // WAIT
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if ({busy, pc, mem_rd} !== {1'b1, 5'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_still_wait: got %h want %h", {busy, pc, mem_rd}, {1'b1, 5'd5, 1'b0});
    end
    pulse_done();                           // IDLE
    n_checks++;
    if ({busy, halted, pc, mem_rd} !== {1'b0, 1'b0, 5'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_idle: got %h want %h", {busy, halted, pc, mem_rd},
               {1'b0, 1'b0, 5'd5, 1'b0});
    end
    saw_rd = 1'b0;
    repeat (4) begin
      step();
      if (mem_rd) saw_rd = 1'b1;
    end
    n_checks++;
    if (saw_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_no_fetch: got %b want %b", saw_rd, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem(9'h1C0);
    mem[0] = 9'h040;
    mem[1] = 9'h1FF;
    do_reset();
    start = 1'b1;
    step();                                 // FETCH
    start = 1'b0;
    repeat (4) step();                      // L, I, IR, IL
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_checks++;
    if ({busy, halted, pc, din, run, mem_rd} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want %h", {busy, halted, pc, din, run, mem_rd}, 18'd0);
    end
  endtask

  task automatic test_wrap();
    fill_mem(9'h1C0);
    mem[31] = 9'h00A;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      start = 1'b1;
      step();                               // FETCH
      start = 1'b0;
      step();                               // LATCH
      step();                               // HALT
    end
    n_checks++;
    if ({halted, pc} !== {1'b1, 5'd31}) begin
      n_fail++;
      $display("FAIL wrap_pc31: got %h want %h", {halted, pc}, {1'b1, 5'd31});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd31}) begin
      n_fail++;
      $display("FAIL wrap_fetch31: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd31});
    end
    step();
    step();                                 // ISSUE
    n_checks++;
    if ({run, pc, din} !== {1'b1, 5'd0, 9'h00A}) begin
      n_fail++;
      $display("FAIL wrap_pc0: got %h want %h", {run, pc, din}, {1'b1, 5'd0, 9'h00A});
    end
    step();                                 // WAIT
    pulse_done();
    n_checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL wrap_fetch0: got %h want %h", {mem_rd, mem_addr}, {1'b1, 5'd0});
    end
  endtask

`ifdef INSTR_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    fill_mem(9'h1C0);
    mem[0] = 9'h00A;
    mem[1] = 9'h00A;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();                                 // WAIT cycle 1
    repeat (14) step();                     // WAIT cycle 15
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL wdog_before: got %b want %b", {busy, err}, 2'b10);
    end
    step();
    n_checks++;
    if ({busy, err, mem_rd} !== 3'b010) begin
      n_fail++;
      $display("FAIL wdog_expire: got %b want %b", {busy, err, mem_rd}, 3'b010);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({err, mem_rd, mem_addr} !== {1'b0, 1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL wdog_clear: got %h want %h", {err, mem_rd, mem_addr}, {1'b0, 1'b1, 5'd1});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mvi();
    test_halt();
    test_fast_done();
    test_stop();
    test_reset_mid();
    test_wrap();
`ifdef INSTR_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 start  in  1  level/pulse; begin or resume issuing from current pc.
REQ-004 stop  in  1  pulse; finish current instruction, then return to IDLE.
REQ-005 done  in  1  one-cycle pulse from control unit: instruction retired.
REQ-006 mem_rdata  in  9  program memory read data, valid one cycle after mem_rd.
REQ-007 mem_rd  out  1  program memory read strobe.
REQ-008 mem_addr  out  5  program memory address; equals pc.
REQ-009 din  out  9  registered word to datapath/CU: instruction, then immediate for mvi.
REQ-010 run  out  1  one-cycle pulse: din holds a valid instruction word.
REQ-011 busy  out  1  high in every state except IDLE and HALT.
REQ-012 halted  out  1  high in HALT.
REQ-013 pc  out  5  program counter.

Function
REQ-014 Word format: op = din[8:6], rx = din[5:3], ry = din[2:0]; op 000 mv, 001 mvi, 010 add, 011 sub, 111 halt (sequencer-only, never issued); 100-110 issued unchanged.
REQ-015 States: IDLE, FETCH, LATCH, ISSUE, IMM_RD, IMM_LATCH, WAIT, HALT.
REQ-016 IDLE: start=1 and stop=0 -> FETCH; start and stop in same cycle -> stay IDLE.
REQ-017 FETCH: mem_rd=1, mem_addr=pc -> LATCH.
REQ-018 LATCH: din <= mem_rdata, pc <= pc+1; op 111 -> HALT, otherwise -> ISSUE.
REQ-019 ISSUE: run=1 for exactly one cycle; op 001 -> IMM_RD, otherwise -> WAIT.
REQ-020 IMM_RD: mem_rd=1, mem_addr=pc -> IMM_LATCH; IMM_LATCH: din <= mem_rdata, pc <= pc+1 -> WAIT.
REQ-021 done_seen flag: set by done=1 in any cycle from the cycle after ISSUE through WAIT; cleared on entry to ISSUE; a done pulse arriving before WAIT is not lost.
REQ-022 WAIT: on done=1 or done_seen=1 -> IDLE if stop_pend, else FETCH.
REQ-023 stop_pend set by stop=1 in any busy state, cleared on entry to IDLE; stop never aborts an issued instruction.
REQ-024 done=1 in IDLE, HALT, FETCH or LATCH is ignored.
REQ-025 pc arithmetic modulo 32: pc=31 increments to 0, no flag.
REQ-026 HALT: run=0, mem_rd=0; start=1 -> FETCH at pc (word after halt), halted cleared; stop in HALT -> IDLE.
REQ-027 start while busy is ignored.
REQ-028 din holds its value in all states not loading it.

Reset
REQ-029 resetn=0 at clock edge, in any state including mid-instruction: state=IDLE, pc=0, din=0, run=0, mem_rd=0, busy=0, halted=0, done_seen=0, stop_pend=0 (plus err=0 and counter=0 under macro).
REQ-030 First cycle after reset release: outputs at reset values; start is sampled from that cycle.

Configuration
REQ-031 Macro INSTR_SEQ_WATCHDOG_EN defined: 4-bit counter clears on ISSUE entry, increments each WAIT cycle; reaching 15 without done -> output err (1 bit) set, state -> IDLE; err sticky until next start or reset.
REQ-032 Macro undefined: no counter, no err port; WAIT waits indefinitely.

Structure
REQ-033 Package instr_seq_pkg: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT), state enum, PC_W=5, WORD_W=9, WDOG_MAX=15.
REQ-034 One sub-module instr_seq_wdog (watchdog counter), instantiated only under INSTR_SEQ_WATCHDOG_EN; FSM stays in instr_seq.

Verification
REQ-035 mem[0]=9'b001_000_000, mem[1]=9'h005, done 2 cycles after run -> run pulse with din=0x040, then din=0x005, pc=2 in WAIT, next FETCH at 2.
REQ-036 mem[0]=9'b000_001_010, done in cycle immediately after run -> done_seen captured, FETCH at pc=1, no hang.
REQ-037 mem[2]=9'b111_000_000 -> no run for that word, halted=1, pc=3; start -> FETCH at 3, halted=0.
REQ-038 stop during WAIT of add at pc=4 -> instruction completes on done, IDLE, pc=5, busy=0, no further mem_rd.
REQ-039 resetn=0 during IMM_LATCH -> next cycle IDLE, pc=0, din=0, run=0; pc=31 fetch wraps next fetch to address 0.
REQ-040 With INSTR_SEQ_WATCHDOG_EN, never assert done -> err=1 after 15 WAIT cycles, state IDLE; start clears err.
